// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares the byte-wide RAM port between IF refills and MEM loads/stores
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_data,
    output logic              if_done,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [1:0]        mem_width,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_done,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wr,
    output logic [7:0]        ram_dout,
    input  logic [7:0]        ram_din,
    output logic              busy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]        state;
    logic              gnt_mem;
    logic              last_mem;
    logic [2:0]        nbytes;
    logic [2:0]        step;
    logic [DATA_W-1:0] wbuf;
    logic [DATA_W-1:0] rbuf;
    logic [DATA_W-1:0] rd_merged;
    logic [1:0]        byte_sel;
    logic [2:0]        mem_n;
    logic              mem_win;
    logic              gnt_req;

    // MEM wins unless it was the last one served while IF is also waiting.
    assign mem_win = mem_req & (~if_req | ~last_mem);
    assign mem_n   = (mem_width == 2'd0) ? 3'd1 : (mem_width == 2'd1) ? 3'd2 : 3'd4;
    assign gnt_req = gnt_mem ? mem_req : if_req;

    // In READ, step k (k>=1) captures byte k-1; step 4 wraps to byte 3.
    assign byte_sel = step[1:0] - 2'd1;

    always_comb begin
        rd_merged = rbuf;
        if (step != 3'd0) begin
            rd_merged[{byte_sel, 3'b000} +: 8] = ram_din;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            gnt_mem   <= 1'b0;
            last_mem  <= 1'b0;
            nbytes    <= 3'd0;
            step      <= 3'd0;
            wbuf      <= '0;
            rbuf      <= '0;
            if_data   <= '0;
            if_done   <= 1'b0;
            mem_rdata <= '0;
            mem_done  <= 1'b0;
            ram_addr  <= '0;
            ram_wr    <= 1'b0;
            ram_dout  <= 8'h00;
            busy      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (mem_req || if_req) begin
                        busy <= 1'b1;
                        step <= 3'd0;
                        rbuf <= '0;
                        if (mem_win) begin
                            gnt_mem  <= 1'b1;
                            last_mem <= 1'b1;
                            nbytes   <= mem_n;
                            ram_addr <= mem_addr;
                            wbuf     <= mem_wdata;
                            ram_dout <= mem_wdata[7:0];
                            ram_wr   <= mem_we;
                            state    <= mem_we ? S_WRITE : S_READ;
                        end else begin
                            gnt_mem  <= 1'b0;
                            last_mem <= 1'b0;
                            nbytes   <= 3'd4;
                            ram_addr <= if_addr;
                            ram_wr   <= 1'b0;
                            state    <= S_READ;
                        end
                    end
                end
                S_READ: begin
                    if (!gnt_req) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        rbuf <= rd_merged;
                        step <= step + 3'd1;
                        if (step + 3'd1 < nbytes) begin
                            ram_addr <= ram_addr + ADDR_W'(1);
                        end
                        if (step == nbytes) begin
                            state <= S_DONE;
                            if (gnt_mem) begin
                                mem_done  <= 1'b1;
                                mem_rdata <= rd_merged;
                            end else begin
                                if_done <= 1'b1;
                                if_data <= rd_merged;
                            end
                        end
                    end
                end
                S_WRITE: begin
                    step <= step + 3'd1;
                    if (step + 3'd1 == nbytes) begin
                        ram_wr   <= 1'b0;
                        mem_done <= 1'b1;
                        state    <= S_DONE;
                    end else begin
                        ram_addr <= ram_addr + ADDR_W'(1);
                        ram_dout <= wbuf[15:8];
                        wbuf     <= {8'h00, wbuf[DATA_W-1:8]};
                    end
                end
                default: begin
                    if_done  <= 1'b0;
                    mem_done <= 1'b0;
                    busy     <= 1'b0;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic [31:0] if_data;
    logic        if_done;
    logic        mem_req = 1'b0;
    logic        mem_we = 1'b0;
    logic [1:0]  mem_width = 2'd0;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_wdata = '0;
    logic [31:0] mem_rdata;
    logic        mem_done;
    logic [31:0] ram_addr;
    logic        ram_wr;
    logic [7:0]  ram_dout;
    logic [7:0]  ram_din = 8'h00;
    logic        busy;

    int checks = 0;
    int errors = 0;

    logic [7:0] ram [logic [31:0]];

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_data   (if_data),
        .if_done   (if_done),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_width (mem_width),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_done  (mem_done),
        .ram_addr  (ram_addr),
        .ram_wr    (ram_wr),
        .ram_dout  (ram_dout),
        .ram_din   (ram_din),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Byte RAM with one-cycle read latency.
    always @(posedge clk) begin
        ram_din <= ram.exists(ram_addr) ? ram[ram_addr] : 8'h00;
        if (ram_wr) ram[ram_addr] = ram_dout;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    logic [31:0] exp_addr [4];
    logic [7:0]  exp_byte [4];
    int          found;
    int          seen;

    initial begin
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_ram_wr", {31'd0, ram_wr}, 32'd0);
        check("rst_ram_addr", ram_addr, 32'd0);
        check("rst_dones", {30'd0, if_done, mem_done}, 32'd0);
        check("rst_rdata", mem_rdata | if_data, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        idle_cycles(2);

        // IF word read
        ram[32'h100] = 8'h13; ram[32'h101] = 8'h05; ram[32'h102] = 8'h10; ram[32'h103] = 8'h00;
        if_addr = 32'h100; if_req = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            check("if_ram_addr", ram_addr, 32'h100 + 32'(k - 1));
            check("if_no_done_early", {31'd0, if_done}, 32'd0);
        end
        @(negedge clk);
        check("if_no_done_t5", {31'd0, if_done}, 32'd0);
        @(negedge clk);
        check("if_done_t6", {31'd0, if_done}, 32'd1);
        check("if_data", if_data, 32'h00100513);
        check("if_mem_done_low", {31'd0, mem_done}, 32'd0);
        if_req = 1'b0;
        idle_cycles(2);

        // MEM byte store
        mem_req = 1'b1; mem_we = 1'b1; mem_width = 2'd0; mem_addr = 32'h2003; mem_wdata = 32'hAABBCCDD;
        @(negedge clk);
        check("sb_ram_wr", {31'd0, ram_wr}, 32'd1);
        check("sb_ram_addr", ram_addr, 32'h2003);
        check("sb_ram_dout", {24'd0, ram_dout}, 32'h0000_00DD);
        check("sb_no_done_t1", {31'd0, mem_done}, 32'd0);
        @(negedge clk);
        check("sb_done_t2", {31'd0, mem_done}, 32'd1);
        check("sb_ram_wr_off", {31'd0, ram_wr}, 32'd0);
        mem_req = 1'b0;
        idle_cycles(2);
        check("sb_ram_content", ram.exists(32'h2004) ? 32'hFFFF : 32'h0, 32'h0);

        // MEM half load
        ram[32'h3000] = 8'h34; ram[32'h3001] = 8'h92; ram[32'h3002] = 8'h77;
        mem_req = 1'b1; mem_we = 1'b0; mem_width = 2'd1; mem_addr = 32'h3000;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            check("lh_no_done_early", {30'd0, if_done, mem_done}, 32'd0);
            check("lh_ram_wr", {31'd0, ram_wr}, 32'd0);
        end
        @(negedge clk);
        check("lh_done_t4", {31'd0, mem_done}, 32'd1);
        check("lh_rdata", mem_rdata, 32'h0000_9234);
        check("lh_if_done_low", {31'd0, if_done}, 32'd0);
        mem_req = 1'b0;
        idle_cycles(2);

        // Both requesters held high from reset: MEM, IF, MEM, IF
        rst = 1'b0;
        ram[32'h700] = 8'h01; ram[32'h701] = 8'h02; ram[32'h702] = 8'h03; ram[32'h703] = 8'h04;
        if_req = 1'b1; if_addr = 32'h100;
        mem_req = 1'b1; mem_we = 1'b0; mem_width = 2'd2; mem_addr = 32'h700;
        @(negedge clk);
        rst = 1'b1;
        for (int n = 0; n < 4; n++) begin
            found = 0;
            for (int c = 0; c < 20 && found == 0; c++) begin
                @(negedge clk);
                if (if_done || mem_done) found = 1;
            end
            check("alt_done_seen", found, 1);
            check("alt_grant_is_mem", {31'd0, mem_done}, (n % 2 == 0) ? 32'd1 : 32'd0);
            check("alt_data", (n % 2 == 0) ? mem_rdata : if_data,
                  (n % 2 == 0) ? 32'h04030201 : 32'h00100513);
            @(negedge clk);
            check("alt_busy_gap", {31'd0, busy}, 32'd0);
            @(negedge clk);
            check("alt_busy_again", {31'd0, busy}, 32'd1);
        end
        if_req = 1'b0; mem_req = 1'b0;
        idle_cycles(3);

        // IF read aborted at t+3, pending MEM byte load then served
        ram[32'h500] = 8'h5A;
        if_addr = 32'h400; if_req = 1'b1;
        seen = 0;
        @(negedge clk);
        mem_req = 1'b1; mem_we = 1'b0; mem_width = 2'd0; mem_addr = 32'h500;
        @(negedge clk);
        seen |= if_done;
        @(negedge clk);
        seen |= if_done;
        check("ab_addr_t3", ram_addr, 32'h402);
        if_req = 1'b0;
        @(negedge clk);
        seen |= if_done;
        check("ab_idle_t4", {31'd0, busy}, 32'd0);
        check("ab_addr_hold", ram_addr, 32'h402);
        @(negedge clk);
        check("ab_mem_grant_addr", ram_addr, 32'h500);
        check("ab_busy_t5", {31'd0, busy}, 32'd1);
        idle_cycles(1);
        seen |= if_done;
        @(negedge clk);
        seen |= if_done;
        check("ab_mem_done_t7", {31'd0, mem_done}, 32'd1);
        check("ab_mem_rdata", mem_rdata, 32'h0000_005A);
        check("ab_no_if_done", seen, 0);
        mem_req = 1'b0;
        idle_cycles(2);

        // Word store wrapping past the top of the address space
        exp_addr[0] = 32'hFFFF_FFFE; exp_addr[1] = 32'hFFFF_FFFF; exp_addr[2] = 32'h0; exp_addr[3] = 32'h1;
        exp_byte[0] = 8'h44; exp_byte[1] = 8'h33; exp_byte[2] = 8'h22; exp_byte[3] = 8'h11;
        mem_req = 1'b1; mem_we = 1'b1; mem_width = 2'd2; mem_addr = 32'hFFFF_FFFE; mem_wdata = 32'h11223344;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("sw_ram_addr", ram_addr, exp_addr[k]);
            check("sw_ram_dout", {24'd0, ram_dout}, {24'd0, exp_byte[k]});
            check("sw_ram_wr", {31'd0, ram_wr}, 32'd1);
        end
        @(negedge clk);
        check("sw_done_t5", {31'd0, mem_done}, 32'd1);
        check("sw_wr_off", {31'd0, ram_wr}, 32'd0);
        mem_req = 1'b0;
        idle_cycles(2);

        // Reset during the second byte of a word store
        mem_req = 1'b1; mem_we = 1'b1; mem_width = 2'd2; mem_addr = 32'h6000; mem_wdata = 32'hCAFEF00D;
        idle_cycles(2);
        check("rw_second_byte_addr", ram_addr, 32'h6001);
        rst = 1'b0;
        #1;
        check("rw_ram_wr_cleared", {31'd0, ram_wr}, 32'd0);
        check("rw_busy_cleared", {31'd0, busy}, 32'd0);
        check("rw_no_done", {31'd0, mem_done}, 32'd0);
        mem_req = 1'b0;
        seen = 0;
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            seen |= mem_done | ram_wr;
        end
        check("rw_no_late_activity", seen, 0);
        check("rw_no_third_byte", ram.exists(32'h6002) ? 32'd1 : 32'd0, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Sequences and shares the single byte-wide RAM port between instruction fetch (IF, icache-miss refill) and the MEM stage (loads/stores).
- Serialises each word, half or byte access into per-byte RAM cycles and reassembles read data little-endian.
- Returns a one-cycle done pulse to the granted requester; the pipeline stall controller uses the done pulses and busy to drive the stall bus.

Parameters:
- ADDR_W, 32, address width of requester and RAM addresses.
- DATA_W, 32, requester data width; fixed at 4 bytes.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- if_req  in  1  IF read request, level; held until if_done or withdrawn.
- if_addr  in  ADDR_W  IF word address.
- if_data  out  DATA_W  fetched instruction; valid while if_done=1.
- if_done  out  1  one-cycle completion pulse to IF.
- mem_req  in  1  MEM request, level.
- mem_we  in  1  1=store, 0=load.
- mem_width  in  2  0=byte, 1=half, 2=word; 3 is treated as word.
- mem_addr  in  ADDR_W  MEM byte address.
- mem_wdata  in  DATA_W  store data; the low N bytes are used.
- mem_rdata  out  DATA_W  load data, zero-extended (sign extension is done in MEM); valid while mem_done=1.
- mem_done  out  1  one-cycle completion pulse to MEM.
- ram_addr  out  ADDR_W  RAM byte address.
- ram_wr  out  1  RAM write strobe.
- ram_dout  out  8  RAM write byte.
- ram_din  in  8  RAM read byte; valid one cycle after its address is driven.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (rst=0, asynchronous): all outputs 0, state=IDLE, byte counters 0, last_grant=IF (so MEM wins the first contention).
  - Reset mid-operation drops ram_wr immediately; no done pulse is issued.
- States: IDLE, READ, WRITE, DONE. All outputs are registered.
- IDLE arbitration, sampled each cycle:
  - Only mem_req high: grant MEM.
  - Only if_req high: grant IF.
  - Both high: grant whichever was not last_grant (alternation, so neither side starves).
  - On grant: latch requester id, address, N bytes (IF: 4; MEM: 1/2/4 per mem_width), mem_we and mem_wdata; set last_grant.
  - Requester inputs are ignored after the grant until DONE.
- READ, grant taken in IDLE at cycle t:
  - ram_addr = addr+i in cycles t+1..t+N; ram_wr=0.
  - Byte i is captured from ram_din at the end of cycle t+2+i into bits [8i+7:8i].
  - Enter DONE in cycle t+N+2.
- WRITE:
  - ram_addr = addr+i, ram_dout = wdata[8i+7:8i], ram_wr=1 in cycles t+1..t+N.
  - Enter DONE in cycle t+N+1; ram_wr=0 from then on.
- DONE (exactly one cycle):
  - Assert the granted requester's done and present its data; the other done stays 0.
  - Unused upper rdata bytes are 0.
  - Next state is IDLE.
  - IDLE in the cycle after DONE samples requests normally, so back-to-back requests are allowed; a requester wanting no repeat must drop req in that cycle.
- Latency:
  - Read: done at t+N+2 (IF word: 6 cycles after grant).
  - Write: done at t+N+1 (word store: 5 cycles after grant).
- Abort:
  - If the granted requester's req falls during READ (e.g. IF flushed by a branch), stop issuing addresses and go to IDLE next cycle with no done pulse.
  - A req drop during WRITE is ignored: the store always completes and pulses done, so no partial store is possible.
- Address arithmetic: modulo 2^ADDR_W; 0xFFFFFFFF+1 = 0x00000000. No alignment check.
- if_data and mem_rdata hold their last value outside DONE; they are checked only under done.

Test Plan:
- IF word read, if_addr=0x100, RAM bytes 0x13,0x05,0x10,0x00:
  - ram_addr 0x100..0x103 in cycles t+1..t+4.
  - if_done=1 only at t+6 with if_data=0x00100513.
- MEM byte store, addr=0x2003, wdata=0xAABBCCDD, width=0:
  - Single ram_wr cycle with ram_addr=0x2003, ram_dout=0xDD.
  - mem_done at t+2.
- MEM half load, width=1, bytes 0x34,0x92: mem_rdata=0x00009234 at mem_done; if_done stays 0.
- if_req and mem_req both held high from reset:
  - Grant order MEM, IF, MEM, IF.
  - busy drops for exactly one IDLE cycle between transactions.
- IF read, if_req dropped at t+3: no further ram_addr changes, no if_done, IDLE at t+4; a pending mem_req is then granted.
- Edge cases:
  - Word store at 0xFFFFFFFE: ram_addr sequence FFFFFFFE, FFFFFFFF, 0, 1.
  - Reset asserted during the second write byte: ram_wr=0 immediately, busy=0, no mem_done.
